// File: rtl/jefloverockets_cpu_handler_pkg.sv
// Shared encodings for the 8-bit accumulator CPU: FSM states, opcodes,
// ALU operations and the uio pin bit positions.
package jefloverockets_cpu_handler_pkg;

  typedef enum logic [2:0] {
    FO_A = 3'd0,
    FO_D = 3'd1,
    FA_A = 3'd2,
    FA_D = 3'd3,
    M_A  = 3'd4,
    M_D  = 3'd5,
    HALT = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5
  } alu_op_t;

  localparam int UIO_RW     = 0;
  localparam int UIO_STROBE = 1;
  localparam int UIO_HALTED = 2;
  localparam logic [7:0] UIO_OE_MASK = 8'b0000_0111;

  // LDI/LDA use PASS so the loaded byte flows through the same zero detector.
  function automatic alu_op_t alu_op_of(input logic [3:0] opc);
    case (opc)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASS;
    endcase
  endfunction

  function automatic logic is_mem_op(input logic [3:0] opc);
    return (opc >= OP_LDA) && (opc <= OP_XOR);
  endfunction

endpackage

// File: rtl/jefloverockets_cpu_handler_cpu_alu.sv
// Combinational ALU: a is the accumulator, b the memory/immediate byte.
module jefloverockets_cpu_handler_cpu_alu
  import jefloverockets_cpu_handler_pkg::*;
(
  input  alu_op_t    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic       carry,
  output logic       zero
);

  logic [8:0] sum;
  logic [8:0] diff;

  // diff[8] is the borrow, i.e. a < b.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = b;
    carry = 1'b0;
    case (op)
      ALU_ADD: begin
        y     = sum[7:0];
        carry = sum[8];
      end
      ALU_SUB: begin
        y     = diff[7:0];
        carry = diff[8];
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = b;
    endcase
    zero = (y == 8'h00);
  end

endmodule

// File: rtl/jefloverockets_cpu_handler.sv
// Tiny Tapeout wrapper around an 8-bit accumulator CPU talking to an external
// 256-byte memory over a multiplexed address/data pin bus.
module jefloverockets_cpu_handler
  import jefloverockets_cpu_handler_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t     state;
  logic [7:0] pc;
  logic [7:0] acc;
  logic [7:0] ir;
  logic [7:0] arg;
  logic       z;
  logic       c;
  logic [3:0] opc;
  logic [7:0] alu_y;
  logic       alu_carry;
  logic       alu_zero;
  logic       strobe;
  logic       rw;
  logic       halted;
  logic       unused_bits;

  assign opc         = ir[7:4];
  assign unused_bits = &{1'b0, uio_in, ir[3:0]};

  // Operand comes straight off the pins: immediate in FA_D, memory in M_D.
  jefloverockets_cpu_handler_cpu_alu u_alu (
    .op    (alu_op_of(opc)),
    .a     (acc),
    .b     (ui_in),
    .y     (alu_y),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FO_A;
      pc    <= RESET_PC;
      acc   <= 8'h00;
      ir    <= 8'h00;
      arg   <= 8'h00;
      z     <= 1'b0;
      c     <= 1'b0;
    end else if (ena) begin
      case (state)
        FO_A: state <= FO_D;
        FO_D: begin
          ir    <= ui_in;
          pc    <= pc + 8'd1;
          state <= FA_A;
        end
        FA_A: state <= FA_D;
        FA_D: begin
          arg   <= ui_in;
          pc    <= pc + 8'd1;
          state <= FO_A;
          // Jump targets deliberately override the increment above.
          case (opc)
            OP_NOP: state <= FO_A;
            OP_LDI: begin
              acc <= alu_y;
              z   <= alu_zero;
            end
            OP_JMP: pc <= ui_in;
            OP_JZ:  if (z) pc <= ui_in;
            OP_JC:  if (c) pc <= ui_in;
            OP_HLT: state <= HALT;
            default: if (is_mem_op(opc)) state <= M_A;
          endcase
        end
        M_A: state <= M_D;
        M_D: begin
          if (opc != OP_STA) begin
            acc <= alu_y;
            z   <= alu_zero;
            if (opc != OP_LDA) c <= alu_carry;
          end
          state <= FO_A;
        end
        HALT:    state <= HALT;
        default: state <= FO_A;
      endcase
    end
  end

  // Pin muxing is a pure decode of registered state, so outputs hold with ena=0.
  always_comb begin
    uo_out = pc;
    strobe = 1'b0;
    rw     = 1'b0;
    halted = 1'b0;
    case (state)
      FO_A, FA_A: strobe = 1'b1;
      M_A: begin
        uo_out = arg;
        strobe = 1'b1;
        rw     = (opc == OP_STA);
      end
      M_D: begin
        if (opc == OP_STA) begin
          uo_out = acc;
          rw     = 1'b1;
        end else begin
          uo_out = arg;
        end
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
    uio_out             = 8'h00;
    uio_out[UIO_RW]     = rw;
    uio_out[UIO_STROBE] = strobe;
    uio_out[UIO_HALTED] = halted;
  end

  assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_jefloverockets_cpu_handler.sv
// Bench for the accumulator CPU: behavioural 256-byte memory on the pin bus,
// bus events checked in order against an expected queue.
module tb_jefloverockets_cpu_handler;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic [7:0]  mem [256];
  logic [7:0]  addr_l;
  // Event encoding: {1'b0, 8'h00, addr} for a strobed address,
  // {1'b1, addr, data} for a memory write.
  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  int          total;
  int          bad;

  jefloverockets_cpu_handler #(.RESET_PC(8'h00)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model and bus monitor ----------------
  assign ui_in = mem[addr_l];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_q.delete();
      addr_l = 8'h00;
    end else if (ena) begin
      if (uio_out[1]) begin
        obs_q.push_back({1'b0, 8'h00, uo_out});
        addr_l = uo_out;
      end else if (uio_out[0]) begin
        obs_q.push_back({1'b1, addr_l, uo_out});
      end
    end
  end

  // ---------------- driver / scoreboard tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    check(tag, {9'h000, obs}, {9'h000, exp});
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    uio_in = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    step(2);
  endtask

  task automatic put(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1);
    mem[a]         = d0;
    mem[a + 8'd1]  = d1;
  endtask

  task automatic exp_s(input logic [7:0] a);
    exp_q.push_back({1'b0, 8'h00, a});
  endtask

  task automatic exp_w(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic run_to_halt(input string tag);
    int n;
    n = 0;
    while (!uio_out[2] && n < 300) begin
      step(1);
      n++;
    end
    check({tag, "_halt_reached"}, {16'h0000, uio_out[2]}, 17'h00001);
  endtask

  task automatic run_to_events(input string tag, input int k);
    int n;
    n = 0;
    while (obs_q.size() < k && n < 300) begin
      step(1);
      n++;
    end
    check({tag, "_events_reached"}, {16'h0000, obs_q.size() >= k}, 17'h00001);
  endtask

  task automatic drain(input string tag, input bit exact);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      logic [16:0] e;
      logic [16:0] o;
      e = exp_q.pop_front();
      o = 'x;
      if (i < obs_q.size()) o = obs_q[i];
      check($sformatf("%s_ev%0d", tag, i), o, e);
    end
    if (exact) check({tag, "_count"}, 17'(obs_q.size()), 17'(n));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    uio_in = 8'h00;

    // Reset values, then first fetch cycle after release.
    do_reset();
    chk8("rst_uo", uo_out, 8'h00);
    chk8("rst_uio", uio_out, 8'h02);
    chk8("rst_oe", uio_oe, 8'h07);
    rst_n = 1'b1;
    #1;
    chk8("c0_uio", uio_out, 8'h02);
    chk8("c0_uo", uo_out, 8'h00);
    step(1);
    chk8("c1_uio", uio_out, 8'h00);
    chk8("c1_uo", uo_out, 8'h00);

    // Store path.
    do_reset();
    put(8'h00, 8'h10, 8'h5A); put(8'h02, 8'h30, 8'h80); put(8'h04, 8'hF0, 8'h00);
    exp_s(8'h00); exp_s(8'h01); exp_s(8'h02); exp_s(8'h03); exp_s(8'h80);
    exp_w(8'h80, 8'h5A); exp_s(8'h04); exp_s(8'h05);
    rst_n = 1'b1;
    run_to_halt("sta");
    drain("sta", 1'b1);
    chk8("sta_halt_uo", uo_out, 8'h06);
    chk8("sta_halt_uio", uio_out, 8'h04);

    // Add with carry, then JC taken.
    do_reset();
    mem[8'h80] = 8'hF0;
    put(8'h00, 8'h10, 8'h20); put(8'h02, 8'h40, 8'h80); put(8'h04, 8'hB0, 8'h10);
    put(8'h10, 8'h30, 8'h90); put(8'h12, 8'hF0, 8'h00);
    exp_s(8'h00); exp_s(8'h01); exp_s(8'h02); exp_s(8'h03); exp_s(8'h80);
    exp_s(8'h04); exp_s(8'h05); exp_s(8'h10); exp_s(8'h11); exp_s(8'h90);
    exp_w(8'h90, 8'h10); exp_s(8'h12); exp_s(8'h13);
    rst_n = 1'b1;
    run_to_halt("add");
    drain("add", 1'b1);
    chk8("add_halt_uo", uo_out, 8'h14);

    // Subtract to zero: JZ taken, JC not taken.
    do_reset();
    mem[8'h81] = 8'h33;
    put(8'h00, 8'h10, 8'h33); put(8'h02, 8'h50, 8'h81); put(8'h04, 8'hA0, 8'h40);
    put(8'h40, 8'hB0, 8'h60); put(8'h42, 8'h30, 8'h90); put(8'h44, 8'hF0, 8'h00);
    exp_s(8'h00); exp_s(8'h01); exp_s(8'h02); exp_s(8'h03); exp_s(8'h81);
    exp_s(8'h04); exp_s(8'h05); exp_s(8'h40); exp_s(8'h41); exp_s(8'h42);
    exp_s(8'h43); exp_s(8'h90); exp_w(8'h90, 8'h00); exp_s(8'h44); exp_s(8'h45);
    rst_n = 1'b1;
    run_to_halt("subz");
    drain("subz", 1'b1);
    chk8("subz_halt_uo", uo_out, 8'h46);

    // Subtract with borrow: JZ not taken, JC taken.
    do_reset();
    mem[8'h81] = 8'h34;
    put(8'h00, 8'h10, 8'h33); put(8'h02, 8'h50, 8'h81); put(8'h04, 8'hA0, 8'h40);
    put(8'h06, 8'hB0, 8'h20); put(8'h20, 8'h30, 8'h90); put(8'h22, 8'hF0, 8'h00);
    exp_s(8'h00); exp_s(8'h01); exp_s(8'h02); exp_s(8'h03); exp_s(8'h81);
    exp_s(8'h04); exp_s(8'h05); exp_s(8'h06); exp_s(8'h07); exp_s(8'h20);
    exp_s(8'h21); exp_s(8'h90); exp_w(8'h90, 8'hFF); exp_s(8'h22); exp_s(8'h23);
    rst_n = 1'b1;
    run_to_halt("subb");
    drain("subb", 1'b1);
    chk8("subb_halt_uo", uo_out, 8'h24);

    // ena stall for 5 cycles in FA_D of the first LDI.
    do_reset();
    put(8'h00, 8'h10, 8'h77); put(8'h02, 8'h30, 8'h90); put(8'h04, 8'hF0, 8'h00);
    exp_s(8'h00); exp_s(8'h01); exp_s(8'h02); exp_s(8'h03); exp_s(8'h90);
    exp_w(8'h90, 8'h77); exp_s(8'h04); exp_s(8'h05);
    rst_n = 1'b1;
    step(3);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk8($sformatf("stall%0d_uo", i), uo_out, 8'h01);
      chk8($sformatf("stall%0d_uio", i), uio_out, 8'h00);
    end
    ena = 1'b1;
    run_to_halt("stall");
    drain("stall", 1'b1);
    chk8("stall_halt_uo", uo_out, 8'h06);

    // PC wrap: JMP FE, NOP at FE/FF, next fetch from 00.
    do_reset();
    put(8'h00, 8'h90, 8'hFE); put(8'hFE, 8'h00, 8'h00);
    exp_s(8'h00); exp_s(8'h01); exp_s(8'hFE); exp_s(8'hFF); exp_s(8'h00);
    rst_n = 1'b1;
    run_to_events("wrap", 5);
    drain("wrap", 1'b0);

    // Reset during M_D of ADD, then read ACC back via STA.
    do_reset();
    mem[8'h80] = 8'hF0;
    put(8'h00, 8'h10, 8'h20); put(8'h02, 8'h40, 8'h80); put(8'h04, 8'hF0, 8'h00);
    rst_n = 1'b1;
    step(9);
    chk8("mid_md_uo", uo_out, 8'h80);
    chk8("mid_md_uio", uio_out, 8'h00);
    rst_n = 1'b0;
    #1;
    chk8("mid_rst_uo", uo_out, 8'h00);
    chk8("mid_rst_uio", uio_out, 8'h02);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    put(8'h00, 8'h30, 8'h90); put(8'h02, 8'hF0, 8'h00);
    exp_s(8'h00); exp_s(8'h01); exp_s(8'h90); exp_w(8'h90, 8'h00);
    exp_s(8'h02); exp_s(8'h03);
    step(1);
    rst_n = 1'b1;
    run_to_halt("mid");
    drain("mid", 1'b1);
    chk8("mid_halt_uo", uo_out, 8'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
